multi_hand_datapath: RTL and testbench

Parametrised card datapath for the Baccarat engine: holds up to `NUM_HANDS` hands of up to `CARDS_PER_HAND` cards each. It draws cards from an internal free-running rank source or from an external override, and keeps a running baccarat score (sum mod 10) per hand. It sits between the round controller and the seven-segment/score display logic. It generalises the fixed two-hand, three-card datapath with a request/ready handshake, per-hand slot pointers, hand clear, full/error detection and deterministic card injection.

---
 rtl/baccarat_pkg.sv | 34 +++
 rtl/rank_source.sv | 30 +++
 rtl/multi_hand_datapath.sv | 149 ++++++++++++++
 tb/tb_multi_hand_datapath.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/baccarat_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | baccarat_pkg                                                         |
// | Shared rank constants, card scoring helpers and datapath FSM states. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package baccarat_pkg;

    localparam int RANK_W = 4;

    localparam logic [RANK_W-1:0] RANK_ACE  = 4'd1;
    localparam logic [RANK_W-1:0] RANK_TEN  = 4'd10;
    localparam logic [RANK_W-1:0] RANK_KING = 4'd13;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SCORE = 1'b1
    } dp_state_t;

    // Court cards and tens count as zero in baccarat.
    function automatic logic [3:0] card_value(input logic [RANK_W-1:0] rank);
        logic [3:0] v;
        v = (rank < RANK_TEN) ? rank : 4'd0;
        return v;
    endfunction

    function automatic logic [3:0] mod10_add(input logic [3:0] score, input logic [3:0] value);
        logic [4:0] t;
        t = {1'b0, score} + {1'b0, value};
        return (t >= 5'd10) ? 4'(t - 5'd10) : t[3:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/rank_source.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rank_source                                                          |
// | Free-running card rank counter cycling 1..13.                        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rank_source
    import baccarat_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    output logic [RANK_W-1:0] o_rank
);

    logic [RANK_W-1:0] r_rank;

    // >= rather than == so an upset value can never escape the 1..13 range.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_rank <= RANK_ACE;
        else if (r_rank >= RANK_KING || r_rank == '0)
            r_rank <= RANK_ACE;
        else
            r_rank <= r_rank + RANK_W'(1);
    end

    assign o_rank = r_rank;

endmodule
`default_nettype wire

// File: rtl/multi_hand_datapath.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | multi_hand_datapath                                                  |
// | Multi-hand baccarat card store with per-hand slot pointers and score.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module multi_hand_datapath
    import baccarat_pkg::*;
#(
    parameter int  NUM_HANDS      = 2,
    parameter int  CARDS_PER_HAND = 3,
    localparam int HIDX_W         = (NUM_HANDS > 1) ? $clog2(NUM_HANDS) : 1,
    localparam int CNT_W          = $clog2(CARDS_PER_HAND + 1)
) (
    input  logic                                  fast_clock,
    input  logic                                  reset,
    input  logic                                  deal_req,
    input  logic [HIDX_W-1:0]                     deal_hand,
    output logic                                  deal_ready,
    input  logic                                  ext_card_en,
    input  logic [3:0]                            ext_card,
    input  logic                                  clear_req,
    input  logic [HIDX_W-1:0]                     clear_hand,
    output logic [NUM_HANDS*CARDS_PER_HAND*4-1:0] cards,
    output logic [NUM_HANDS*4-1:0]                scores,
    output logic [NUM_HANDS*CNT_W-1:0]            counts,
    output logic [NUM_HANDS-1:0]                  hand_full,
    output logic                                  deal_done,
    output logic                                  deal_err
);

    dp_state_t                             r_state;
    dp_state_t                             w_state_nxt;
    logic [NUM_HANDS*CARDS_PER_HAND*4-1:0] r_cards;
    logic [NUM_HANDS*4-1:0]                r_scores;
    logic [NUM_HANDS*CNT_W-1:0]            r_counts;
    logic [HIDX_W-1:0]                     r_hand;
    logic [3:0]                            r_value;
    logic                                  r_deal_done;
    logic                                  r_deal_err;

    logic [RANK_W-1:0] w_src_rank;
    logic [RANK_W-1:0] w_rank;
    logic [CNT_W-1:0]  w_cur_count;
    logic              w_cur_full;
    logic              w_hand_ok;
    logic              w_ext_ok;
    logic              w_deal_acc;
    logic              w_deal_go;
    logic              w_deal_bad;
    logic              w_clear_go;

    rank_source u_rank_source (
        .clk    (fast_clock),
        .rst    (reset),
        .o_rank (w_src_rank)
    );

    genvar gh;
    generate
        for (gh = 0; gh < NUM_HANDS; gh++) begin : g_full
            assign hand_full[gh] = (r_counts[gh*CNT_W +: CNT_W] == CNT_W'(CARDS_PER_HAND));
        end
    endgenerate

    // Out-of-range hand indices match no entry, so they read as invalid.
    always_comb begin
        w_cur_count = '0;
        w_cur_full  = 1'b0;
        w_hand_ok   = 1'b0;
        for (int h = 0; h < NUM_HANDS; h++) begin
            if (deal_hand == HIDX_W'(h)) begin
                w_cur_count = r_counts[h*CNT_W +: CNT_W];
                w_cur_full  = hand_full[h];
                w_hand_ok   = 1'b1;
            end
        end
    end

    assign w_rank     = ext_card_en ? ext_card : w_src_rank;
    assign w_ext_ok   = !ext_card_en || (ext_card >= RANK_ACE && ext_card <= RANK_KING);
    assign w_deal_acc = deal_req && deal_ready;
    assign w_deal_go  = w_deal_acc && w_hand_ok && !w_cur_full && w_ext_ok;
    assign w_deal_bad = w_deal_acc && !(w_hand_ok && !w_cur_full && w_ext_ok);
    assign w_clear_go = (r_state == ST_IDLE) && clear_req;

    always_ff @(posedge fast_clock or posedge reset) begin
        if (reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_deal_go) w_state_nxt = ST_SCORE;
            ST_SCORE: w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        deal_ready = (r_state == ST_IDLE) && !clear_req && !reset;
    end

    // Clear (IDLE), card write (IDLE) and score commit (SCORE) are mutually exclusive.
    always_ff @(posedge fast_clock or posedge reset) begin
        if (reset) begin
            r_cards     <= '0;
            r_scores    <= '0;
            r_counts    <= '0;
            r_hand      <= '0;
            r_value     <= '0;
            r_deal_done <= 1'b0;
            r_deal_err  <= 1'b0;
        end else begin
            r_deal_done <= (r_state == ST_SCORE);
            r_deal_err  <= w_deal_bad;
            if (w_deal_go) begin
                r_hand  <= deal_hand;
                r_value <= card_value(w_rank);
            end
            for (int h = 0; h < NUM_HANDS; h++) begin
                if (w_clear_go && clear_hand == HIDX_W'(h)) begin
                    for (int s = 0; s < CARDS_PER_HAND; s++)
                        r_cards[(h*CARDS_PER_HAND+s)*4 +: 4] <= 4'd0;
                    r_counts[h*CNT_W +: CNT_W] <= '0;
                    r_scores[h*4 +: 4]         <= 4'd0;
                end else if (w_deal_go && deal_hand == HIDX_W'(h)) begin
                    for (int s = 0; s < CARDS_PER_HAND; s++)
                        if (w_cur_count == CNT_W'(s))
                            r_cards[(h*CARDS_PER_HAND+s)*4 +: 4] <= w_rank;
                    r_counts[h*CNT_W +: CNT_W] <= w_cur_count + CNT_W'(1);
                end else if (r_state == ST_SCORE && r_hand == HIDX_W'(h)) begin
                    r_scores[h*4 +: 4] <= mod10_add(r_scores[h*4 +: 4], r_value);
                end
            end
        end
    end

    assign cards     = r_cards;
    assign scores    = r_scores;
    assign counts    = r_counts;
    assign deal_done = r_deal_done;
    assign deal_err  = r_deal_err;

endmodule
`default_nettype wire

// File: tb/tb_multi_hand_datapath.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_multi_hand_datapath                                               |
// | Directed plus randomized checks against a behavioural hand model.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_multi_hand_datapath;

    localparam int NH  = 3;
    localparam int CPH = 3;
    localparam int HW  = 2;
    localparam int CW  = 2;

    logic                  fast_clock  = 1'b0;
    logic                  reset       = 1'b1;
    logic                  deal_req    = 1'b0;
    logic [HW-1:0]         deal_hand   = '0;
    logic                  deal_ready;
    logic                  ext_card_en = 1'b0;
    logic [3:0]            ext_card    = 4'd0;
    logic                  clear_req   = 1'b0;
    logic [HW-1:0]         clear_hand  = '0;
    logic [NH*CPH*4-1:0]   cards;
    logic [NH*4-1:0]       scores;
    logic [NH*CW-1:0]      counts;
    logic [NH-1:0]         hand_full;
    logic                  deal_done;
    logic                  deal_err;

    int total = 0;
    int bad   = 0;
    int edge_cnt = 0;

    int m_cards [NH][CPH];
    int m_cnt   [NH];
    int m_sum   [NH];
    int m_score [NH];

    multi_hand_datapath #(
        .NUM_HANDS      (NH),
        .CARDS_PER_HAND (CPH)
    ) dut (
        .fast_clock  (fast_clock),
        .reset       (reset),
        .deal_req    (deal_req),
        .deal_hand   (deal_hand),
        .deal_ready  (deal_ready),
        .ext_card_en (ext_card_en),
        .ext_card    (ext_card),
        .clear_req   (clear_req),
        .clear_hand  (clear_hand),
        .cards       (cards),
        .scores      (scores),
        .counts      (counts),
        .hand_full   (hand_full),
        .deal_done   (deal_done),
        .deal_err    (deal_err)
    );

    always #5 fast_clock = ~fast_clock;

    // Rising edges seen since reset release.
    always @(posedge fast_clock or posedge reset) begin
        if (reset)
            edge_cnt <= 0;
        else
            edge_cnt <= edge_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic int value_of(input int rank);
        return (rank >= 1 && rank <= 9) ? rank : 0;
    endfunction

    task automatic model_reset();
        for (int h = 0; h < NH; h++) begin
            for (int s = 0; s < CPH; s++) m_cards[h][s] = 0;
            m_cnt[h] = 0; m_sum[h] = 0; m_score[h] = 0;
        end
    endtask

    task automatic check_state(input string tag);
        logic [63:0] ec, es, en, ef;
        ec = '0; es = '0; en = '0; ef = '0;
        for (int h = 0; h < NH; h++) begin
            for (int s = 0; s < CPH; s++) ec[(h*CPH+s)*4 +: 4] = m_cards[h][s][3:0];
            es[h*4 +: 4]   = m_score[h][3:0];
            en[h*CW +: CW] = m_cnt[h][CW-1:0];
            ef[h]          = (m_cnt[h] == CPH);
        end
        check({tag, ".cards"},  64'(cards),     ec);
        check({tag, ".scores"}, 64'(scores),    es);
        check({tag, ".counts"}, 64'(counts),    en);
        check({tag, ".full"},   64'(hand_full), ef);
    endtask

    // Called at edge+1 with the datapath idle; returns at edge+1, idle again.
    task automatic do_deal(input int h, input bit en, input int ext);
        int  rank;
        bit  ok;
        rank = en ? ext : (edge_cnt % 13) + 1;
        ok = 1'b1;
        if (h >= NH) ok = 1'b0;
        else if (m_cnt[h] >= CPH) ok = 1'b0;
        if (en && (ext < 1 || ext > 13)) ok = 1'b0;
        deal_req    = 1'b1;
        deal_hand   = h[HW-1:0];
        ext_card_en = en;
        ext_card    = ext[3:0];
        check("deal.ready", 64'(deal_ready), 64'(1));
        @(posedge fast_clock); #1;
        deal_req    = 1'b0;
        ext_card_en = 1'($urandom);
        ext_card    = 4'($urandom);
        if (ok) begin
            m_cards[h][m_cnt[h]] = rank;
            m_cnt[h]++;
            m_sum[h] += value_of(rank);
        end
        check("deal.err1",  64'(deal_err),  64'(!ok));
        check("deal.done1", 64'(deal_done), 64'(0));
        check_state("deal1");
        @(posedge fast_clock); #1;
        if (ok) m_score[h] = m_sum[h] % 10;
        check("deal.done2", 64'(deal_done), 64'(ok));
        check("deal.err2",  64'(deal_err),  64'(0));
        check_state("deal2");
    endtask

    task automatic do_clear(input int h, input bit with_deal);
        clear_req  = 1'b1;
        clear_hand = h[HW-1:0];
        if (with_deal) begin
            deal_req    = 1'b1;
            deal_hand   = h[HW-1:0];
            ext_card_en = 1'b1;
            ext_card    = 4'd5;
        end
        #1;
        check("clr.ready", 64'(deal_ready), 64'(0));
        @(posedge fast_clock); #1;
        clear_req = 1'b0;
        deal_req  = 1'b0;
        if (h < NH) begin
            for (int s = 0; s < CPH; s++) m_cards[h][s] = 0;
            m_cnt[h] = 0; m_sum[h] = 0; m_score[h] = 0;
        end
        check("clr.err",  64'(deal_err),  64'(0));
        check("clr.done", 64'(deal_done), 64'(0));
        check_state("clear");
        @(posedge fast_clock); #1;
        check("clr.done2", 64'(deal_done), 64'(0));
        check("clr.err2",  64'(deal_err),  64'(0));
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge fast_clock);
        #1;
        check("rst.ready", 64'(deal_ready), 64'(0));
        check("rst.done",  64'(deal_done),  64'(0));
        check("rst.err",   64'(deal_err),   64'(0));
        check_state("rst");
        reset = 1'b0;
        #1;
        check("rel.ready", 64'(deal_ready), 64'(1));

        // Thirteen idle edges bring the source back round to an ace.
        repeat (13) @(posedge fast_clock);
        #1;
        do_deal(0, 1'b0, 0);
        check("wrap.rank", 64'(cards[3:0]), 64'(1));
        do_clear(0, 1'b0);

        do_deal(0, 1'b1, 7);
        do_deal(0, 1'b1, 8);
        check("h0.score", 64'(scores[3:0]), 64'(5));

        do_deal(1, 1'b1, 13);
        do_deal(1, 1'b1, 10);
        do_deal(1, 1'b1, 9);
        check("h1.full", 64'(hand_full[1]), 64'(1));
        do_deal(1, 1'b1, 4);

        do_deal(2, 1'b1, 15);
        do_deal(2, 1'b1, 0);
        do_deal(3, 1'b1, 6);

        do_clear(0, 1'b1);

        // Reset while the score commit is pending.
        deal_req = 1'b1; deal_hand = 2'd0; ext_card_en = 1'b1; ext_card = 4'd3;
        @(posedge fast_clock); #1;
        deal_req = 1'b0;
        reset    = 1'b1;
        #1;
        model_reset();
        check("midrst.ready", 64'(deal_ready), 64'(0));
        check("midrst.done",  64'(deal_done),  64'(0));
        check_state("midrst");
        @(posedge fast_clock); #1;
        check("midrst.done2", 64'(deal_done), 64'(0));
        reset = 1'b0;
        #1;
        do_deal(0, 1'b1, 4);
        check("post.score", 64'(scores[3:0]), 64'(4));

        for (int i = 0; i < 120; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 2) begin
                do_clear($urandom_range(0, 3), 1'($urandom_range(0, 1)));
            end else begin
                int h;
                h = ($urandom_range(0, 7) == 0) ? 3 : $urandom_range(0, 2);
                do_deal(h, 1'($urandom_range(0, 1)), $urandom_range(0, 15));
            end
            repeat ($urandom_range(0, 2)) @(posedge fast_clock);
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
